// File: rtl/key_note_sequencer.sv
// Piano key front end: sync, per-key debounce, monophonic lowest-key arbiter,
// note-on/note-off events over a valid/ready handshake.
module key_note_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic       higher_8,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic       evt_on,
  output logic [3:0] evt_note,
  output logic       note_active,
  output logic [3:0] active_note
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_ON,
    HOLD,
    SEND_OFF
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       key_s1, key_s2, deb;
  logic             oct_s1, oct_s2;
  logic [CNT_W-1:0] cnt [8];

  state_t     state_q, state_d;
  logic [3:0] note_q, note_d;
  logic [2:0] own_q, own_d;
  logic [2:0] pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1 <= '0;
      key_s2 <= '0;
      oct_s1 <= 1'b0;
      oct_s2 <= 1'b0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      oct_s1 <= higher_8;
      oct_s2 <= oct_s1;
    end
  end

  // A level is accepted only after it differs for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (key_s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= key_s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    pick = '0;
    for (int i = 7; i >= 0; i--) begin
      if (deb[i]) pick = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      note_q  <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      own_q   <= own_d;
    end
  end

  // Owner and pitch are frozen from SEND_ON until the OFF handshake
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    own_d   = own_q;
    unique case (state_q)
      IDLE: begin
        if (|deb) begin
          own_d   = pick;
          note_d  = {oct_s2, pick};
          state_d = SEND_ON;
        end
      end
      SEND_ON: begin
        if (evt_ready) state_d = HOLD;
      end
      HOLD: begin
        if (!deb[own_q]) state_d = SEND_OFF;
      end
      SEND_OFF: begin
        if (evt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign evt_valid   = (state_q == SEND_ON) ||
                       (state_q == SEND_OFF);
  assign evt_on      = (state_q == SEND_ON);
  assign evt_note    = note_q;
  assign note_active = (state_q == HOLD);
  assign active_note = (state_q == IDLE) ? 4'd0 : note_q;

endmodule

// File: tb/tb_key_note_sequencer.sv
// Randomised scoreboard bench for key_note_sequencer against a
// windowed-debounce / event-list reference model.
module tb_key_note_sequencer;

  localparam int D = 4;

  localparam int M_IDLE = 0;
  localparam int M_ON   = 1;
  localparam int M_HOLD = 2;
  localparam int M_OFF  = 3;

  logic       clk;
  logic       rst;
  logic [7:0] key;
  logic       higher_8;
  logic       evt_ready;
  logic       evt_valid;
  logic       evt_on;
  logic [3:0] evt_note;
  logic       note_active;
  logic [3:0] active_note;

  key_note_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .higher_8(higher_8),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_on(evt_on),
    .evt_note(evt_note),
    .note_active(note_active),
    .active_note(active_note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h @%0t",
                  name, act, req, $time);
  endtask

  // Reference model state
  logic [4:0] exp_q[$];
  logic [7:0] m_s1, m_s2, m_deb;
  logic       m_o1, m_o2;
  logic [7:0] hist [D];
  int         m_mode;
  int         m_own;
  logic [3:0] m_note;

  function automatic int lowest(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      m_o1 = 1'b0; m_o2 = 1'b0;
      for (int j = 0; j < D; j++) hist[j] = '0;
      m_mode = M_IDLE; m_own = 0; m_note = '0;
      exp_q.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (m_deb != 0) begin
          m_own  = lowest(m_deb);
          m_note = 4'(m_own + (m_o2 ? 8 : 0));
          m_mode = M_ON;
          exp_q.push_back({1'b1, m_note});
        end
        M_ON: if (evt_ready) m_mode = M_HOLD;
        M_HOLD: if (!m_deb[m_own]) begin
          m_mode = M_OFF;
          exp_q.push_back({1'b0, m_note});
        end
        default: if (evt_ready) m_mode = M_IDLE;
      endcase
      // a level flips once the last D synced samples all disagree
      for (int j = 0; j < D - 1; j++) hist[j] = hist[j+1];
      hist[D-1] = m_s2;
      for (int b = 0; b < 8; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (hist[j][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = ~m_deb[b];
      end
      m_s2 = m_s1; m_s1 = key;
      m_o2 = m_o1; m_o1 = higher_8;
    end
  end

  // Monitor
  logic       stall_prev = 1'b0;
  logic [4:0] prev_evt;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      logic       ev, ea;
      logic [3:0] en;
      ev = (m_mode == M_ON) || (m_mode == M_OFF);
      ea = (m_mode == M_HOLD);
      en = (m_mode == M_IDLE) ? 4'd0 : m_note;
      check("status",
            {evt_valid, evt_valid & evt_on, note_active, active_note},
            {ev, m_mode == M_ON, ea, en});
      if (stall_prev)
        check("stall_hold", {evt_valid, evt_on, evt_note},
              {1'b1, prev_evt});
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          check("event_unexpected", {evt_on, evt_note}, 5'h1f);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          check("event", {evt_on, evt_note}, e);
        end
      end
      stall_prev = evt_valid && !evt_ready;
      prev_evt   = {evt_on, evt_note};
    end
  end

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    rst = 1'b1; key = '0; higher_8 = 1'b0; evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {evt_valid, evt_on, evt_note, note_active, active_note},
          '0);
    @(posedge clk); #2;
    rst = 1'b0;

    // single key, latency to evt_valid
    key = 8'h04;
    n = 0;
    while (n < 20) begin
      @(posedge clk); n++; #1;
      if (evt_valid) break;
    end
    #1;
    check("on_latency", n, 7);
    run(10);
    key = 8'h00;
    run(12);

    // short glitch never propagates
    key = 8'h10;
    run(3);
    key = 8'h00;
    run(12);

    // two keys, upper octave; owner release hands over
    higher_8 = 1'b1;
    key = 8'h22;
    run(15);
    key = 8'h20;
    run(20);
    key = 8'h00;
    run(15);
    higher_8 = 1'b0;

    // backpressure during SEND_ON
    evt_ready = 1'b0;
    key = 8'h01;
    run(20);
    evt_ready = 1'b1;
    run(5);

    // octave toggles in HOLD do not re-pitch
    repeat (4) begin
      higher_8 = ~higher_8;
      run(3);
    end
    key = 8'h00;
    run(15);
    higher_8 = 1'b0;

    // async reset in HOLD
    key = 8'h08;
    run(15);
    check("hold_before_rst", note_active, 1'b1);
    @(posedge clk); #3;
    rst = 1'b1; key = 8'h00;
    #1;
    check("async_rst",
          {evt_valid, note_active, active_note}, '0);
    @(posedge clk); #2;
    rst = 1'b0;
    run(15);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) key = 8'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) higher_8 = ~higher_8;
      run(1);
    end

    key = 8'h00;
    evt_ready = 1'b1;
    run(40);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
